gpio_in_filter30: RTL

- Input-conditioning stage directly downstream of the GPIO pin interface. Consumes gpio_pin_in30 and n_gpio_pin_oe30.
- Synchronises each pin into the pclk30 domain, debounces it with a programmable stable-count, and detects rising/falling edges on the filtered level.
- Latches edge events into per-pin sticky interrupt status bits, cleared by a write-1-to-clear strobe, and raises a combined interrupt toward the APB/interrupt controller.

---
 rtl/gpio_in_filter30.sv | 52 +++++
 1 files changed

// File: rtl/gpio_in_filter30.sv
// gpio_in_filter30: per-pin synchroniser, programmable debounce, edge detect and sticky W1C interrupt status
module gpio_in_filter30 #(
  parameter int DATA_WIDTH   = 16,
  parameter int DB_CNT_WIDTH = 8
) (
  input  logic                    pclk30,
  input  logic                    n_p_reset30,
  input  logic [DATA_WIDTH-1:0]   gpio_pin_in30,
  input  logic [DATA_WIDTH-1:0]   n_gpio_pin_oe30,
  input  logic [DB_CNT_WIDTH-1:0] db_limit,
  input  logic [DATA_WIDTH-1:0]   rise_en,
  input  logic [DATA_WIDTH-1:0]   fall_en,
  input  logic [DATA_WIDTH-1:0]   irq_clr,
  output logic [DATA_WIDTH-1:0]   sync_in,
  output logic [DATA_WIDTH-1:0]   filt_in,
  output logic [DATA_WIDTH-1:0]   irq_status,
  output logic                    irq
);
  localparam logic [DB_CNT_WIDTH-1:0] cnt_one = 1;
  localparam logic [DB_CNT_WIDTH:0]   lim_one = 1;
  logic [DATA_WIDTH-1:0] s1, upd, set;
  logic [DATA_WIDTH-1:0][DB_CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [DB_CNT_WIDTH:0] lim;
  // one extra bit keeps cnt+1 from wrapping when compared against the limit
  assign lim = (db_limit == '0) ? lim_one : {1'b0, db_limit};
  always_comb begin
    upd = '0;
    cnt_nxt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      upd[i] = (sync_in[i] != filt_in[i]) && (({1'b0, cnt[i]} + lim_one) >= lim);
      cnt_nxt[i] = (sync_in[i] == filt_in[i] || upd[i]) ? '0 : cnt[i] + cnt_one;
    end
  end
  // the new filtered level equals sync_in on an update edge
  assign set = n_gpio_pin_oe30 & upd & ((sync_in & rise_en) | (~sync_in & fall_en));
  assign irq = |irq_status;
  always_ff @(posedge pclk30) begin
    if (!n_p_reset30) begin
      s1         <= '0;
      sync_in    <= '0;
      filt_in    <= '0;
      cnt        <= '0;
      irq_status <= '0;
    end else begin
      s1         <= gpio_pin_in30;
      sync_in    <= s1;
      filt_in    <= filt_in ^ upd;
      cnt        <= cnt_nxt;
      irq_status <= set | (irq_status & ~irq_clr);
    end
  end
endmodule
